// File: rtl/bop_pkg.sv
// rtl/bop_pkg.sv - shared state enum, default button count and index-width helper
package bop_pkg;

  typedef enum logic [2:0] {
    RELEASE,
    IDLE,
    ARMED,
    HOLD,
    REPORT
  } state_t;

  localparam int DEF_NUM_BTN = 4;

  // clog2 that never returns less than 1, so a single-button build still has an index bit
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bop_action_capture_if.sv
// rtl/bop_action_capture_if.sv - action record valid/ready channel to the game FSM
interface bop_action_capture_if
  import bop_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN
);
  localparam int ID_W = idx_w(NUM_BTN);

  logic            act_valid;
  logic            act_ready;
  logic [ID_W-1:0] act_id;
  logic            act_multi;
  logic            act_long;

  modport master (
    output act_valid,
    output act_id,
    output act_multi,
    output act_long,
    input  act_ready
  );

  modport slave (
    input  act_valid,
    input  act_id,
    input  act_multi,
    input  act_long,
    output act_ready
  );

endinterface

// File: rtl/bop_edge_detect.sv
// rtl/bop_edge_detect.sv - registers previous button levels and flags rising edges
module bop_edge_detect
  import bop_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] rise
);

  logic [NUM_BTN-1:0] btn_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn_db;
    end
  end

  assign rise = btn_db & ~btn_prev;

endmodule

// File: rtl/bop_action_capture.sv
// rtl/bop_action_capture.sv - captures first press in the response window and reports one action record
// Hold timing and long-press detection are built only when BOP_LONG_PRESS_EN is defined.
module bop_action_capture
  import bop_pkg::*;
#(
  parameter int NUM_BTN     = DEF_NUM_BTN,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BTN-1:0]    btn_db,
  input  logic                  arm,
  bop_action_capture_if.master  act
);

  localparam int ID_W = idx_w(NUM_BTN);

  if ((64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow to count HOLD_CYCLES");
  end

  logic [NUM_BTN-1:0] rise;

  bop_edge_detect #(
    .NUM_BTN (NUM_BTN)
  ) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_db (btn_db),
    .rise   (rise)
  );

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_BTN-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  function automatic logic many_set(input logic [NUM_BTN-1:0] v);
    return (v & (v - NUM_BTN'(1))) != '0;
  endfunction

  state_t          state, state_nxt;
  logic            rec_valid, valid_nxt;
  logic [ID_W-1:0] rec_id, id_nxt;
  logic            rec_multi, multi_nxt;

`ifdef BOP_LONG_PRESS_EN
  logic             rec_long, long_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [NUM_BTN-1:0] other_rise;

  assign other_rise = rise & ~(NUM_BTN'(1) << rec_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_long <= 1'b0;
      hold_cnt <= '0;
    end else begin
      rec_long <= long_nxt;
      hold_cnt <= cnt_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASE;
      rec_valid <= 1'b0;
      rec_id    <= '0;
      rec_multi <= 1'b0;
    end else begin
      state     <= state_nxt;
      rec_valid <= valid_nxt;
      rec_id    <= id_nxt;
      rec_multi <= multi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = rec_valid;
    id_nxt    = rec_id;
    multi_nxt = rec_multi;
`ifdef BOP_LONG_PRESS_EN
    long_nxt  = rec_long;
    cnt_nxt   = hold_cnt;
`endif
    case (state)
      RELEASE: begin
        if (btn_db == '0) state_nxt = IDLE;
      end
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        // a rise in the same cycle that arm drops still counts as a capture
        if (rise != '0) begin
          id_nxt    = lowest_idx(rise);
          multi_nxt = many_set(rise);
`ifdef BOP_LONG_PRESS_EN
          long_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = HOLD;
`else
          valid_nxt = 1'b1;
          state_nxt = REPORT;
`endif
        end else if (!arm) begin
          state_nxt = IDLE;
        end
      end
`ifdef BOP_LONG_PRESS_EN
      HOLD: begin
        if (other_rise != '0) multi_nxt = 1'b1;
        if (hold_cnt >= CNT_W'(HOLD_CYCLES)) begin
          long_nxt  = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = REPORT;
        end else begin
          cnt_nxt = hold_cnt + CNT_W'(1);
          if (!btn_db[rec_id]) begin
            valid_nxt = 1'b1;
            state_nxt = REPORT;
          end
        end
      end
`endif
      REPORT: begin
        if (act.act_ready) begin
          valid_nxt = 1'b0;
          state_nxt = RELEASE;
        end
      end
      default: state_nxt = RELEASE;
    endcase
  end

  assign act.act_valid = rec_valid;
  assign act.act_id    = rec_id;
  assign act.act_multi = rec_multi;
`ifdef BOP_LONG_PRESS_EN
  assign act.act_long  = rec_long;
`else
  assign act.act_long  = 1'b0;
`endif

endmodule

// File: tb/tb_bop_action_capture.sv
// tb/tb_bop_action_capture.sv - directed self-checking bench for bop_action_capture
module tb_bop_action_capture;

`ifdef BOP_LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif
  localparam int HC = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_db;
  logic       arm;

  int total = 0;
  int bad   = 0;

  bop_action_capture_if #(.NUM_BTN(4)) act_if ();

  bop_action_capture #(
    .NUM_BTN     (4),
    .HOLD_CYCLES (HC),
    .CNT_W       (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_db (btn_db),
    .arm    (arm),
    .act    (act_if.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // press pattern, release after 'hold' edges (0 = keep held), drop arm after 'drop' edges (0 = never)
  task automatic press(input logic [3:0] pat, input int hold, input int drop, output int lat);
    btn_db = pat;
    lat = 0;
    while (!act_if.act_valid && lat < 100) begin
      step();
      lat++;
      if (hold != 0 && lat == hold) btn_db = 4'b0000;
      if (drop != 0 && lat == drop) arm = 1'b0;
    end
  endtask

  task automatic ack(input string tag);
    act_if.act_ready = 1'b1;
    step();
    check(tag, act_if.act_valid, 1'b0);
    act_if.act_ready = 1'b0;
  endtask

  task automatic rearm();
    btn_db = 4'b0000;
    arm = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    int lat;
    bit seen;
    bit moved;
    logic [1:0] id0;
    logic m0, l0;

    rst_n = 1'b0;
    btn_db = 4'b0010;
    arm = 1'b0;
    act_if.act_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", act_if.act_valid, 1'b0);
    check("rst_id", act_if.act_id, 2'd0);
    check("rst_multi", act_if.act_multi, 1'b0);
    check("rst_long", act_if.act_long, 1'b0);

    // button held through reset must not be reported
    rst_n = 1'b1;
    arm = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      step();
      if (act_if.act_valid) seen = 1'b1;
    end
    check("held_thru_reset", seen, 1'b0);
    btn_db = 4'b0000;
    repeat (3) begin
      step();
      if (act_if.act_valid) seen = 1'b1;
    end
    check("after_release", seen, 1'b0);

    // single short press with ready already high
    act_if.act_ready = 1'b1;
    press(4'b0100, 10, 0, lat);
    check("short_lat", lat, LP ? 11 : 1);
    check("short_id", act_if.act_id, 2'd2);
    check("short_multi", act_if.act_multi, 1'b0);
    check("short_long", act_if.act_long, 1'b0);
    step();
    check("short_pulse", act_if.act_valid, 1'b0);
    act_if.act_ready = 1'b0;
    rearm();

    // same-cycle chord, then stall the handshake
    press(4'b1010, 3, 0, lat);
    check("chord_lat", lat, LP ? 4 : 1);
    check("chord_id", act_if.act_id, 2'd1);
    check("chord_multi", act_if.act_multi, 1'b1);
    id0 = act_if.act_id;
    m0 = act_if.act_multi;
    l0 = act_if.act_long;
    moved = 1'b0;
    repeat (50) begin
      step();
      if (!act_if.act_valid || act_if.act_id !== id0 || act_if.act_multi !== m0 || act_if.act_long !== l0)
        moved = 1'b1;
    end
    check("stall_stable", moved, 1'b0);
    ack("stall_ack");
    rearm();

    // long press, never released
    press(4'b0001, 0, 0, lat);
    check("long_lat", lat, LP ? HC + 2 : 1);
    check("long_id", act_if.act_id, 2'd0);
    check("long_long", act_if.act_long, LP ? 1'b1 : 1'b0);
    check("long_multi", act_if.act_multi, 1'b0);
    ack("long_ack");
    rearm();

    // second button rising while the first is held
    btn_db = 4'b0001;
    step();
    step();
    btn_db = 4'b0101;
    step();
    btn_db = 4'b0100;
    lat = 0;
    while (!act_if.act_valid && lat < 50) begin
      step();
      lat++;
    end
    check("late_valid", act_if.act_valid, 1'b1);
    check("late_id", act_if.act_id, 2'd0);
    check("late_multi", act_if.act_multi, LP ? 1'b1 : 1'b0);
    ack("late_ack");
    rearm();

    // arm drops in the same cycle as the rise
    arm = 1'b0;
    press(4'b0100, 2, 0, lat);
    check("race_lat", lat, LP ? 3 : 1);
    check("race_id", act_if.act_id, 2'd2);
    ack("race_ack");
    btn_db = 4'b0000;
    repeat (3) step();

    // press while the window is closed is discarded
    seen = 1'b0;
    btn_db = 4'b0001;
    repeat (3) begin
      step();
      if (act_if.act_valid) seen = 1'b1;
    end
    btn_db = 4'b0000;
    arm = 1'b1;
    repeat (6) begin
      step();
      if (act_if.act_valid) seen = 1'b1;
    end
    check("closed_window", seen, 1'b0);

    // arm dropped after capture does not cancel the action
    press(4'b1000, 6, 2, lat);
    check("drop_lat", lat, LP ? 7 : 1);
    check("drop_id", act_if.act_id, 2'd3);
    ack("drop_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
